// File: rtl/blink_clk_gen_if.sv
// Memory-mapped slave bus shared by the blink time base and led_ctrl.
// Combinational read data; writes are single-cycle strobes.
// No backpressure: every write strobe is accepted in the cycle it is presented.
interface blink_clk_gen_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/blink_clk_gen.sv
// Blink time base: prescaler + programmable divider yield a 32 Hz tick; a 5-bit phase gives 16/8/1 Hz levels.
// Latency: outputs and tick_o update one clk_sys_i cycle after the tick condition; register reads are combinational.
// No backpressure: bus writes take effect on the next edge; RESTART beats a DIV write, which beats a tick.
module blink_clk_gen #(
    parameter int MM_ADDR_WIDTH       = 8,
    parameter int MM_DATA_WIDTH       = 16,
    parameter int REG_ADDR_BLINK_DIV  = 'h0C,
    parameter int REG_ADDR_BLINK_CTRL = 'h0D,
    parameter int PRE_DIV             = 64,
    parameter int DIV_RST             = 12206
) (
    input  logic             clk_sys_i,
    input  logic             rst_n_i,
    blink_clk_gen_if.slave   mm_s,
    output logic             clk_16hz_o,
    output logic             clk_8hz_o,
    output logic             clk_1hz_o,
    output logic             tick_o
);
    localparam int                       PRE_W    = $clog2(PRE_DIV);
    localparam logic [PRE_W-1:0]         PRE_LAST = PRE_W'(PRE_DIV - 1);
    localparam logic [MM_ADDR_WIDTH-1:0] ADDR_DIV = MM_ADDR_WIDTH'(REG_ADDR_BLINK_DIV);
    localparam logic [MM_ADDR_WIDTH-1:0] ADDR_CTL = MM_ADDR_WIDTH'(REG_ADDR_BLINK_CTRL);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [15:0]      div_cnt_q, div_cnt_d;
    logic [15:0]      div_q, div_d;
    logic             en_q, en_d;
    logic [4:0]       ph_q, ph_d;
    logic             tick_q, tick_d;

    logic div_wr, ctrl_wr, restart, pre_tick, tick_cond;
    logic [MM_DATA_WIDTH-1:0] rdata_c;

    // Next-state: count while enabled, then let DIV writes and RESTART override the count in rising priority.
    always_comb begin
        div_wr    = mm_s.we && (mm_s.addr == ADDR_DIV);
        ctrl_wr   = mm_s.we && (mm_s.addr == ADDR_CTL);
        restart   = ctrl_wr && mm_s.wdata[1];
        pre_tick  = en_q && (pre_cnt_q == PRE_LAST);
        tick_cond = pre_tick && (div_cnt_q == div_q);

        pre_cnt_d = pre_cnt_q;
        div_cnt_d = div_cnt_q;
        div_d     = div_q;
        en_d      = en_q;
        ph_d      = ph_q;
        tick_d    = 1'b0;

        if (en_q) begin
            pre_cnt_d = pre_tick ? '0 : pre_cnt_q + 1'b1;
            if (pre_tick) begin
                div_cnt_d = tick_cond ? 16'd0 : div_cnt_q + 16'd1;
            end
            if (tick_cond) begin
                ph_d   = ph_q + 5'd1;
                tick_d = 1'b1;
            end
        end

        if (ctrl_wr) begin
            en_d = mm_s.wdata[0];
        end

        // A new divisor restarts the period from scratch; a coincident tick is dropped.
        if (div_wr) begin
            div_d     = 16'(mm_s.wdata);
            pre_cnt_d = '0;
            div_cnt_d = 16'd0;
            ph_d      = ph_q;
            tick_d    = 1'b0;
        end

        if (restart) begin
            pre_cnt_d = '0;
            div_cnt_d = 16'd0;
            ph_d      = 5'd0;
            tick_d    = 1'b0;
        end
    end

    // State registers; reset lands on the default divisor with counting enabled.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_cnt_q <= '0;
            div_cnt_q <= 16'd0;
            div_q     <= 16'(DIV_RST);
            en_q      <= 1'b1;
            ph_q      <= 5'd0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            div_cnt_q <= div_cnt_d;
            div_q     <= div_d;
            en_q      <= en_d;
            ph_q      <= ph_d;
            tick_q    <= tick_d;
        end
    end

    // Read mux; forced to zero while reset is held so led_ctrl sees a quiet bus.
    always_comb begin
        rdata_c = '0;
        if (rst_n_i) begin
            if (mm_s.addr == ADDR_DIV) begin
                rdata_c = MM_DATA_WIDTH'(div_q);
            end else if (mm_s.addr == ADDR_CTL) begin
                rdata_c = MM_DATA_WIDTH'({ph_q, 9'b0, 1'b0, en_q});
            end
        end
    end

    assign mm_s.rdata = rdata_c;
    assign clk_16hz_o = ph_q[0];
    assign clk_8hz_o  = ph_q[1];
    assign clk_1hz_o  = ph_q[4];
    assign tick_o     = tick_q;
endmodule

// File: tb/tb_blink_clk_gen.sv
// Bench for blink_clk_gen with a small prescaler: register table, timing sequences, random bus traffic.
// Reference model tracks elapsed enabled cycles against the period PRE_DIV*(DIV+1).
// Outputs are sampled 1 time unit after each rising edge.
module tb_blink_clk_gen;
    localparam int PRE_DIV = 4;
    localparam int DIV_RST = 12206;
    localparam logic [7:0] A_DIV  = 8'h0C;
    localparam logic [7:0] A_CTRL = 8'h0D;
    localparam logic [7:0] A_NONE = 8'h0E;

    logic clk_sys, rst_n;
    logic c16, c8, c1, tick;

    blink_clk_gen_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) mm ();

    blink_clk_gen #(
        .MM_ADDR_WIDTH(8), .MM_DATA_WIDTH(16),
        .REG_ADDR_BLINK_DIV('h0C), .REG_ADDR_BLINK_CTRL('h0D),
        .PRE_DIV(PRE_DIV), .DIV_RST(DIV_RST)
    ) dut (
        .clk_sys_i(clk_sys), .rst_n_i(rst_n), .mm_s(mm),
        .clk_16hz_o(c16), .clk_8hz_o(c8), .clk_1hz_o(c1), .tick_o(tick)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference state
    int m_div, m_en, m_elapsed, m_ph, m_tick;

    function int m_period();
        return PRE_DIV * (m_div + 1);
    endfunction

    function int m_read(input logic [7:0] a);
        if (a == A_DIV)  return m_div;
        if (a == A_CTRL) return (m_ph << 11) | m_en;
        return 0;
    endfunction

    task model_reset();
        m_div = DIV_RST; m_en = 1; m_elapsed = 0; m_ph = 0; m_tick = 0;
    endtask

    task model_edge(input logic we, input logic [7:0] a, input logic [15:0] wd);
        m_tick = 0;
        if (we && a == A_CTRL && wd[1]) begin
            m_elapsed = 0;
            m_ph = 0;
        end else if (we && a == A_DIV) begin
            m_div = int'(wd);
            m_elapsed = 0;
        end else if (m_en != 0) begin
            m_elapsed++;
            if (m_elapsed == m_period()) begin
                m_elapsed = 0;
                m_ph = (m_ph + 1) % 32;
                m_tick = 1;
            end
        end
        if (we && a == A_CTRL) m_en = int'(wd[0]);
    endtask

    task check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function int m_outs();
        return m_tick * 8 + ((m_ph >> 4) & 1) * 4 + ((m_ph >> 1) & 1) * 2 + (m_ph & 1);
    endfunction

    task step(input logic we, input logic [7:0] a, input logic [15:0] wd);
        mm.we = we; mm.addr = a; mm.wdata = wd;
        @(posedge clk_sys);
        model_edge(we, a, wd);
        #1;
        mm.we = 1'b0;
        check("outs{tick,1hz,8hz,16hz}", int'({tick, c1, c8, c16}), m_outs());
    endtask

    task idle();
        step(1'b0, A_NONE, 16'h0);
    endtask

    task rd(input string name, input logic [7:0] a, input int exp);
        mm.addr = a;
        #1;
        check(name, int'(mm.rdata), exp);
    endtask

    task wait_tick(output int n, input int bound);
        n = 0;
        do begin
            idle();
            n++;
        end while (!tick && n < bound);
        if (!tick) check("tick_timeout", 0, 1);
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  raddr;
        int          exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n, k, r, ra;
        logic [15:0] rw;

        tbl[0] = '{1'b0, A_NONE, 16'h0000, A_DIV,  12206};
        tbl[1] = '{1'b0, A_NONE, 16'h0000, A_CTRL, 'h0001};
        tbl[2] = '{1'b0, A_NONE, 16'h0000, A_NONE, 0};
        tbl[3] = '{1'b1, A_NONE, 16'hFFFF, A_DIV,  12206};
        tbl[4] = '{1'b1, A_NONE, 16'hFFFF, A_CTRL, 'h0001};
        tbl[5] = '{1'b1, A_CTRL, 16'hFFFC, A_CTRL, 'h0000};
        tbl[6] = '{1'b1, A_CTRL, 16'h0001, A_CTRL, 'h0001};
        tbl[7] = '{1'b1, A_DIV,  16'h0001, A_DIV,  1};

        rst_n = 1'b1; mm.we = 1'b0; mm.addr = A_DIV; mm.wdata = 16'h0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_outs", int'({tick, c1, c8, c16}), 0);
        check("reset_rdata", int'(mm.rdata), 0);
        @(posedge clk_sys);
        #1 rst_n = 1'b1;

        // Register table
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            rd($sformatf("table%0d_read", i), tbl[i].raddr, tbl[i].exp);
        end

        // DIV=1: tick every 8 cycles, phase visible in CTRL
        for (int i = 0; i < 17; i++) begin
            wait_tick(n, 20);
            check("div1_tick_period", n, 8);
            rd("div1_ctrl_ph", A_CTRL, (((i + 1) % 32) << 11) | 1);
        end

        // Disable mid-period, hold 50 cycles, resume with the remaining count
        idle(); idle(); idle();
        step(1'b1, A_CTRL, 16'h0000);
        for (int i = 0; i < 50; i++) begin
            idle();
            check("disabled_no_tick", int'(tick), 0);
        end
        step(1'b1, A_CTRL, 16'h0001);
        k = m_period() - m_elapsed;
        wait_tick(n, 20);
        check("resume_remaining", n, k);

        // RESTART at ph=13
        k = 0;
        while (m_ph != 13 && k < 400) begin idle(); k++; end
        rd("ph13_ctrl", A_CTRL, (13 << 11) | 1);
        step(1'b1, A_CTRL, 16'h0003);
        check("restart_outs", int'({tick, c1, c8, c16}), 0);
        rd("restart_ctrl", A_CTRL, 'h0001);

        // RESTART in the cycle a tick is due
        k = 0;
        while (m_elapsed != m_period() - 1 && k < 20) begin idle(); k++; end
        step(1'b1, A_CTRL, 16'h0003);
        check("restart_vs_tick", int'(tick), 0);
        rd("restart_vs_tick_ctrl", A_CTRL, 'h0001);
        wait_tick(n, 20);
        check("after_restart_period", n, 8);

        // DIV=0: tick every PRE_DIV cycles; unmapped write has no effect
        step(1'b1, A_DIV, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            wait_tick(n, 10);
            check("div0_tick_period", n, 4);
        end
        step(1'b1, A_NONE, 16'h1234);
        rd("unmapped_div", A_DIV, 0);
        rd("unmapped_ctrl", A_CTRL, m_read(A_CTRL));
        rd("unmapped_read", A_NONE, 0);

        // Random bus traffic against the model
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      step(1'b1, A_DIV, 16'($urandom_range(0, 3)));
            else if (r == 1) begin
                rw = 16'($urandom);
                if ($urandom_range(0, 2) != 0) rw[0] = 1'b1;
                step(1'b1, A_CTRL, rw);
            end
            else if (r == 2) step(1'b1, A_NONE, 16'($urandom));
            else             idle();
            ra = int'($urandom_range(0, 3));
            case (ra)
                0:       rd("rand_read_div", A_DIV, m_read(A_DIV));
                1:       rd("rand_read_ctrl", A_CTRL, m_read(A_CTRL));
                2:       rd("rand_read_none", A_NONE, m_read(A_NONE));
                default: begin
                    rw = 16'($urandom);
                    rd("rand_read_any", rw[7:0], m_read(rw[7:0]));
                end
            endcase
        end

        // Reset mid-run, then first tick after a full default period
        mm.addr = A_DIV;
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outs", int'({tick, c1, c8, c16}), 0);
        check("midrun_reset_rdata", int'(mm.rdata), 0);
        @(posedge clk_sys);
        #3 rst_n = 1'b1;
        model_reset();
        rd("post_reset_div", A_DIV, DIV_RST);
        rd("post_reset_ctrl", A_CTRL, 'h0001);
        wait_tick(n, 50000);
        check("post_reset_first_tick", n, PRE_DIV * (DIV_RST + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
